// File: rtl/life_grid_engine.sv
// Game-of-Life cell array with a row-per-cycle generation engine, shadow commit and registered read port.
// Generation: GRID_H compute cycles + 1 commit cycle. Edits and starts are refused while busy, never queued.
module life_grid_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int TICK_DIV = 1000000,
  parameter int SEED     = 0,
  parameter int XW       = $clog2(GRID_W),
  parameter int YW       = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          run,
  input  logic          step,
  input  logic          clear,
  input  logic          toggle,
  input  logic [XW-1:0] cur_x,
  input  logic [YW-1:0] cur_y,
  input  logic          wrap,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic          rd_cell,
  output logic          busy,
  output logic [15:0]   gen_count
);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_COMMIT} state_t;

  localparam int             TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  TICK_ONE = TW'(1);
  localparam logic [YW-1:0]  ROW_LAST = YW'(GRID_H - 1);
  localparam logic [YW-1:0]  ROW_ONE  = YW'(1);
  localparam logic [XW:0]    X_LIM    = (XW + 1)'(GRID_W);
  localparam logic [YW:0]    Y_LIM    = (YW + 1)'(GRID_H);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GRID_W-1:0]   r_cur [GRID_H];
  logic [GRID_W-1:0]   r_nxt [GRID_H];
  logic [YW-1:0]       r_row;
  logic [TW-1:0]       r_tick;
  logic [15:0]         r_gen;
  logic                r_wrap;
  logic                r_pend;
  logic                r_rd;

  logic                w_idle;
  logic                w_compute;
  logic                w_commit;
  logic                w_tog_ok;
  logic                w_rd_ok;
  logic                w_trig;
  logic                w_go;
  logic [YW-1:0]       w_up_idx;
  logic [YW-1:0]       w_dn_idx;
  logic [GRID_W-1:0]   w_row_up;
  logic [GRID_W-1:0]   w_row_mid;
  logic [GRID_W-1:0]   w_row_dn;
  logic [GRID_W+1:0]   w_ext_up;
  logic [GRID_W+1:0]   w_ext_mid;
  logic [GRID_W+1:0]   w_ext_dn;
  logic [GRID_W-1:0]   w_new_row;

  function automatic logic [GRID_W-1:0] seed_row(input int y);
    logic [GRID_W-1:0] row_v;
    row_v = '0;
    if (SEED == 1) begin
      case (y)
        0:       row_v[1]   = 1'b1;
        1:       row_v[2]   = 1'b1;
        2:       row_v[2:0] = 3'b111;
        default: row_v      = '0;
      endcase
    end
    return row_v;
  endfunction

  assign w_rd_ok  = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
  assign w_tog_ok = toggle && w_idle && ({1'b0, cur_x} < X_LIM) && ({1'b0, cur_y} < Y_LIM);
  // A start that collides with an edit is remembered in r_pend and taken next cycle.
  assign w_trig   = r_pend || (step && !run) || (run && (r_tick == TICK_MAX));
  assign w_go     = w_idle && w_trig && !w_tog_ok;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_go) w_state_nxt = S_COMPUTE;
        S_COMPUTE: if (r_row == ROW_LAST) w_state_nxt = S_COMMIT;
        S_COMMIT:  w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_idle    = (r_state == S_IDLE);
    w_compute = (r_state == S_COMPUTE);
    w_commit  = (r_state == S_COMMIT);
    busy      = !w_idle;
  end

  // Neighbour rows: vertical wrap or dead rows beyond the top/bottom edge.
  always_comb begin
    w_up_idx  = (r_row == '0) ? ROW_LAST : r_row - ROW_ONE;
    w_dn_idx  = (r_row == ROW_LAST) ? '0 : r_row + ROW_ONE;
    w_row_mid = r_cur[r_row];
    w_row_up  = ((r_row != '0) || r_wrap) ? r_cur[w_up_idx] : '0;
    w_row_dn  = ((r_row != ROW_LAST) || r_wrap) ? r_cur[w_dn_idx] : '0;
  end

  // Pad each row by one column either side; ext[x+1] holds column x.
  assign w_ext_up  = {r_wrap & w_row_up[0],  w_row_up,  r_wrap & w_row_up[GRID_W-1]};
  assign w_ext_mid = {r_wrap & w_row_mid[0], w_row_mid, r_wrap & w_row_mid[GRID_W-1]};
  assign w_ext_dn  = {r_wrap & w_row_dn[0],  w_row_dn,  r_wrap & w_row_dn[GRID_W-1]};

  for (genvar gx = 0; gx < GRID_W; gx++) begin : g_col
    logic [3:0] w_cnt;
    assign w_cnt = 4'(w_ext_up[gx])  + 4'(w_ext_up[gx+1])  + 4'(w_ext_up[gx+2]) +
                   4'(w_ext_mid[gx])                        + 4'(w_ext_mid[gx+2]) +
                   4'(w_ext_dn[gx])  + 4'(w_ext_dn[gx+1])  + 4'(w_ext_dn[gx+2]);
    assign w_new_row[gx] = (w_cnt == 4'd3) || (w_row_mid[gx] && (w_cnt == 4'd2));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < GRID_H; i++) begin
        r_cur[i] <= seed_row(i);
        r_nxt[i] <= '0;
      end
      r_row  <= '0;
      r_tick <= '0;
      r_gen  <= '0;
      r_wrap <= 1'b0;
      r_pend <= 1'b0;
      r_rd   <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < GRID_H; i++) begin
        r_cur[i] <= '0;
        r_nxt[i] <= '0;
      end
      r_row  <= '0;
      r_tick <= '0;
      r_gen  <= '0;
      r_pend <= 1'b0;
      r_rd   <= 1'b0;
    end else begin
      // Reading nxt during commit makes the next read already show the new generation.
      if (!w_rd_ok) begin
        r_rd <= 1'b0;
      end else if (w_commit) begin
        r_rd <= r_nxt[rd_y][rd_x];
      end else begin
        r_rd <= r_cur[rd_y][rd_x];
      end

      if (w_tog_ok) begin
        r_cur[cur_y][cur_x] <= ~r_cur[cur_y][cur_x];
      end

      if (w_idle) begin
        if (w_go) begin
          r_tick <= '0;
          r_pend <= 1'b0;
          r_wrap <= wrap;
        end else begin
          r_pend <= w_trig;
          if (!run) begin
            r_tick <= '0;
          end else if (r_tick != TICK_MAX) begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
      end

      if (w_compute) begin
        r_nxt[r_row] <= w_new_row;
        if (r_row != ROW_LAST) begin
          r_row <= r_row + ROW_ONE;
        end
      end

      if (w_commit) begin
        for (int i = 0; i < GRID_H; i++) begin
          r_cur[i] <= r_nxt[i];
        end
        r_gen <= r_gen + 16'd1;
        r_row <= '0;
      end
    end
  end

  assign rd_cell   = r_rd;
  assign gen_count = r_gen;

endmodule
